// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - Video and CPU request/response bundle for vram_arbiter
//
// Purpose: groups the chroni video-fetch port and the CPU VRAM-window port.
// master = requesters (chroni + CPU bus decode), slave = vram_arbiter.
// Signals:
//   vid_req/vid_addr -> vid_ack, vid_data/vid_valid         video read channel
//   cpu_wr/cpu_rd/cpu_addr/cpu_wdata -> cpu_rdata/cpu_rvalid CPU access channel
//   cpu_busy, err_overflow                                   CPU flow control / status
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              cpu_wr;
  logic              cpu_rd;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_busy;
  logic              err_overflow;

  modport master (
    output vid_req, vid_addr, cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
    input  vid_ack, vid_data, vid_valid, cpu_rdata, cpu_rvalid, cpu_busy, err_overflow
  );

  modport slave (
    input  vid_req, vid_addr, cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
    output vid_ack, vid_data, vid_valid, cpu_rdata, cpu_rvalid, cpu_busy, err_overflow
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - Single-port VRAM arbiter for chroni video fetch and CPU window
//
// Purpose: per-cycle grant of the VRAM port to video reads (priority) or CPU
// accesses, with a starvation guard, a CPU write FIFO and a 2-cycle read return.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   bus (slave)     video and CPU channels, see vram_arbiter_if
//   mem_addr/mem_we/mem_wdata  VRAM command, combinational from the grant
//   mem_rdata       VRAM read data, valid the cycle after the address
module vram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  vram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {GNT_IDLE, GNT_VID, GNT_CPU} grant_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_t;

  // CPU write FIFO; pointers carry one extra wrap bit to tell full from empty
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              fifo_empty;
  logic              fifo_full;

  logic              rd_pending;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  starve_cnt;
  tag_t              tag_s1;

  logic              vid_valid_q;
  logic [DATA_W-1:0] vid_data_q;
  logic              cpu_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              err_q;

  grant_t            grant;
  logic              cpu_pending;
  logic              push;
  logic              pop;
  logic              rd_grant;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // A pending read only becomes eligible once the FIFO drains, so reads never
  // overtake earlier writes; either way the CPU side counts as waiting.
  assign cpu_pending = !fifo_empty || rd_pending;

  always_comb begin
    grant = GNT_IDLE;
    if (reset)                                           grant = GNT_IDLE;
    else if (cpu_pending && (starve_cnt == STARVE_LIM))  grant = GNT_CPU;
    else if (bus.vid_req)                                grant = GNT_VID;
    else if (cpu_pending)                                grant = GNT_CPU;
  end

  // FIFO head has precedence over a read within a CPU grant
  assign pop      = (grant == GNT_CPU) && !fifo_empty;
  assign rd_grant = (grant == GNT_CPU) && fifo_empty;
  // Full is judged before any same-cycle pop: a write at full is always dropped
  assign push     = bus.cpu_wr && !fifo_full && !reset;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (grant)
      GNT_VID: mem_addr = bus.vid_addr;
      GNT_CPU: begin
        if (!fifo_empty) begin
          mem_addr  = fifo_addr[rd_ptr[PTR_W-1:0]];
          mem_wdata = fifo_data[rd_ptr[PTR_W-1:0]];
          mem_we    = 1'b1;
        end else begin
          mem_addr  = rd_addr;
        end
      end
      default: ;
    endcase
  end

  assign bus.vid_ack = (grant == GNT_VID);

  // FIFO storage needs no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= bus.cpu_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_pending   <= 1'b0;
      rd_addr      <= '0;
      starve_cnt   <= '0;
      tag_s1       <= TAG_NONE;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // rd_grant implies rd_pending, so a strobe in the same cycle is ignored anyway
      if (rd_grant) begin
        rd_pending <= 1'b0;
      end else if (bus.cpu_rd && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_addr    <= bus.cpu_addr;
      end

      if (bus.cpu_wr && fifo_full) err_q <= 1'b1;

      if (!cpu_pending || (grant == GNT_CPU))
        starve_cnt <= '0;
      else if ((grant == GNT_VID) && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 1'b1;

      // Stage 1 tags the access issued this cycle; stage 2 captures mem_rdata
      if (grant == GNT_VID) tag_s1 <= TAG_VID;
      else if (rd_grant)    tag_s1 <= TAG_CPU;
      else                  tag_s1 <= TAG_NONE;

      vid_valid_q  <= (tag_s1 == TAG_VID);
      cpu_rvalid_q <= (tag_s1 == TAG_CPU);
      if (tag_s1 == TAG_VID) vid_data_q  <= mem_rdata;
      if (tag_s1 == TAG_CPU) cpu_rdata_q <= mem_rdata;
    end
  end

  // Outputs are forced low for every cycle reset is high, including the first
  assign bus.vid_valid    = vid_valid_q && !reset;
  assign bus.vid_data     = reset ? '0 : vid_data_q;
  assign bus.cpu_rvalid   = cpu_rvalid_q && !reset;
  assign bus.cpu_rdata    = reset ? '0 : cpu_rdata_q;
  assign bus.cpu_busy     = (fifo_full || rd_pending) && !reset;
  assign bus.err_overflow = err_q && !reset;

endmodule
